// File: rtl/sys_ctrl_pkg.sv
// sys_ctrl_pkg: shared command codes, FSM state encoding and fixed ALU operand addresses
package sys_ctrl_pkg;
   localparam logic [7:0] CMD_RF_WR   = 8'hAA;
   localparam logic [7:0] CMD_RF_RD   = 8'hBB;
   localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
   localparam logic [7:0] CMD_ALU_NOP = 8'hDD;
   localparam int OPA_ADDR = 0;
   localparam int OPB_ADDR = 1;
   typedef enum logic [2:0] {
      IDLE,
      WR_ADDR,
      WR_DATA,
      RD_ADDR,
      OP_A,
      OP_B,
      ALU_FUN_W
   } state_t;
endpackage

// File: rtl/sys_ctrl_rx_frame_timer.sv
// frame_timer: inter-byte timeout down-counter
//   clk, rst_n : clock, async active-low reset
//   clr        : reload to TIMEOUT-1
//   en         : count down one per cycle while high
//   expired    : count exhausted while enabled
module frame_timer #(
   parameter int TIMEOUT = 1024
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expired
);
   localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   logic [W-1:0] cnt_q, cnt_d;
   always_comb cnt_d = clr ? W'(TIMEOUT - 1) : (en && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;
   assign expired = en && cnt_q == '0;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
endmodule

// File: rtl/sys_ctrl_rx.sv
// sys_ctrl_rx: receive-side command frame decoder driving register-file and ALU strobes
//   CLK, RST            : clock, async active-low reset
//   RX_P_DATA, RX_D_VLD : received byte and its one-cycle valid
//   WrEn, RdEn          : register-file write/read strobes (one cycle)
//   Address, WrData     : register-file address/data, held after strobe
//   ALU_EN, ALU_FUN     : ALU start strobe and held function code
//   CLK_EN              : ALU clock-gate enable
module sys_ctrl_rx
   import sys_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter int FUN_WIDTH  = 4,
   parameter int TIMEOUT    = 1024
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] RX_P_DATA,
   input  logic                  RX_D_VLD,
   output logic                  WrEn,
   output logic                  RdEn,
   output logic [ADDR_WIDTH-1:0] Address,
   output logic [DATA_WIDTH-1:0] WrData,
   output logic                  ALU_EN,
   output logic [FUN_WIDTH-1:0]  ALU_FUN,
   output logic                  CLK_EN
);
   state_t                state_q, state_d;
   logic                  wr_en_q, wr_en_d;
   logic                  rd_en_q, rd_en_d;
   logic                  alu_en_q, alu_en_d;
   logic                  clk_en_q, clk_en_d;
   logic [ADDR_WIDTH-1:0] address_q, address_d;
   logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
   logic [FUN_WIDTH-1:0]  alu_fun_q, alu_fun_d;
   logic                  expired;
   // Held in reload while idle so every frame starts with a full budget
   frame_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk     (CLK),
      .rst_n   (RST),
      .clr     (RX_D_VLD || state_q == IDLE),
      .en      (state_q != IDLE),
      .expired (expired)
   );
   always_comb begin
      state_d   = state_q;
      wr_en_d   = 1'b0;
      rd_en_d   = 1'b0;
      alu_en_d  = 1'b0;
      address_d = address_q;
      wr_data_d = wr_data_q;
      alu_fun_d = alu_fun_q;
      if (RX_D_VLD) begin
         case (state_q)
            IDLE:
               state_d = (RX_P_DATA == CMD_RF_WR)   ? WR_ADDR   :
                         (RX_P_DATA == CMD_RF_RD)   ? RD_ADDR   :
                         (RX_P_DATA == CMD_ALU_OP)  ? OP_A      :
                         (RX_P_DATA == CMD_ALU_NOP) ? ALU_FUN_W : IDLE;
            WR_ADDR: begin
               address_d = RX_P_DATA[ADDR_WIDTH-1:0];
               state_d   = WR_DATA;
            end
            WR_DATA: begin
               wr_data_d = RX_P_DATA;
               wr_en_d   = 1'b1;
               state_d   = IDLE;
            end
            RD_ADDR: begin
               address_d = RX_P_DATA[ADDR_WIDTH-1:0];
               rd_en_d   = 1'b1;
               state_d   = IDLE;
            end
            OP_A: begin
               address_d = ADDR_WIDTH'(OPA_ADDR);
               wr_data_d = RX_P_DATA;
               wr_en_d   = 1'b1;
               state_d   = OP_B;
            end
            OP_B: begin
               address_d = ADDR_WIDTH'(OPB_ADDR);
               wr_data_d = RX_P_DATA;
               wr_en_d   = 1'b1;
               state_d   = ALU_FUN_W;
            end
            ALU_FUN_W: begin
               alu_fun_d = RX_P_DATA[FUN_WIDTH-1:0];
               alu_en_d  = 1'b1;
               state_d   = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end else if (expired) begin
         state_d = IDLE;
      end
      // Registered from next state so the gate opens on entry to ALU_FUN_W and covers the ALU_EN cycle
      clk_en_d = (state_d == ALU_FUN_W) || alu_en_d;
   end
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q   <= IDLE;
         wr_en_q   <= 1'b0;
         rd_en_q   <= 1'b0;
         alu_en_q  <= 1'b0;
         clk_en_q  <= 1'b0;
         address_q <= '0;
         wr_data_q <= '0;
         alu_fun_q <= '0;
      end else begin
         state_q   <= state_d;
         wr_en_q   <= wr_en_d;
         rd_en_q   <= rd_en_d;
         alu_en_q  <= alu_en_d;
         clk_en_q  <= clk_en_d;
         address_q <= address_d;
         wr_data_q <= wr_data_d;
         alu_fun_q <= alu_fun_d;
      end
   end
   assign WrEn    = wr_en_q;
   assign RdEn    = rd_en_q;
   assign ALU_EN  = alu_en_q;
   assign CLK_EN  = clk_en_q;
   assign Address = address_q;
   assign WrData  = wr_data_q;
   assign ALU_FUN = alu_fun_q;
endmodule

// File: doc/sys_ctrl_rx.md
# sys_ctrl_rx

Receive-side system controller. Consumes synchronized command bytes from the UART receive path and decodes command frames. It issues register-file write and read strobes, and ALU enable and function strobes, to the register file and ALU. It also drives the ALU clock-gate enable. Read results are returned through the transmit-side controller and are outside this block.

## Interface
Parameters:
- DATA_WIDTH, 8, width of command bytes and register-file data.
- ADDR_WIDTH, 4, register-file address width; taken from the low bits of the address byte.
- FUN_WIDTH, 4, ALU function code width; taken from the low bits of the function byte.
- TIMEOUT, 1024, idle cycles allowed between bytes of one frame before the frame is abandoned.

Ports:
- CLK  in  1  single system clock; all logic is on its rising edge.
- RST  in  1  asynchronous, active-low reset.
- RX_P_DATA  in  DATA_WIDTH  received byte; valid only while RX_D_VLD=1.
- RX_D_VLD  in  1  one-cycle byte-valid pulse; each high cycle is one byte.
- WrEn  out  1  register-file write strobe, exactly one cycle per write.
- RdEn  out  1  register-file read strobe, exactly one cycle per read.
- Address  out  ADDR_WIDTH  register-file address; held after the strobe.
- WrData  out  DATA_WIDTH  register-file write data; held after the strobe.
- ALU_EN  out  1  ALU start strobe, exactly one cycle per operation.
- ALU_FUN  out  FUN_WIDTH  ALU function code; held after the strobe.
- CLK_EN  out  1  ALU clock-gate enable.

## Operation
- Command codes (first byte of each frame):
  - 0xAA: RF write. Frame: cmd, addr, data.
  - 0xBB: RF read. Frame: cmd, addr.
  - 0xCC: ALU operation with operands. Frame: cmd, opA, opB, fun.
  - 0xDD: ALU operation without operands. Frame: cmd, fun.
  - Any other first byte is discarded; the block stays in IDLE.
- States:
  - IDLE; 0xAA→WR_ADDR, 0xBB→RD_ADDR, 0xCC→OP_A, 0xDD→ALU_FUN_W.
  - WR_ADDR: latch Address→WR_DATA.
  - WR_DATA: latch WrData, pulse WrEn→IDLE.
  - RD_ADDR: latch Address, pulse RdEn→IDLE.
  - OP_A: Address=0, WrData=byte, pulse WrEn→OP_B.
  - OP_B: Address=1, WrData=byte, pulse WrEn→ALU_FUN_W.
  - ALU_FUN_W: latch ALU_FUN, pulse ALU_EN→IDLE.
- State advances only on a CLK edge with RX_D_VLD=1. Without RX_D_VLD, the state and all held outputs are unchanged.
- CLK_EN:
  - High while the state is ALU_FUN_W.
  - Also high during the cycle ALU_EN is high.
  - Low otherwise, including in OP_A and OP_B.
- Timeout:
  - A counter runs in every state except IDLE and clears on each accepted byte.
  - When it reaches TIMEOUT-1 with no byte, the next edge returns the block to IDLE. No strobe is issued for the abandoned frame.
  - If RX_D_VLD arrives on the expiry edge, the byte is accepted and timeout is ignored.
- Upper bits of the address and function bytes beyond ADDR_WIDTH/FUN_WIDTH are ignored.

## Timing
- All outputs are registered.
- Reset values:
  - WrEn, RdEn, ALU_EN, CLK_EN: 0.
  - Address, WrData, ALU_FUN: 0.
  - State: IDLE; timeout counter: 0.
- Strobe latency: the strobe is high in the cycle after the edge that accepts the terminating byte. Address, WrData and ALU_FUN are valid in the same cycle and hold until overwritten.
- Back-to-back bytes (RX_D_VLD high on consecutive cycles) are all accepted.
- 0xCC with consecutive bytes produces WrEn pulses one cycle apart when opA and opB are consecutive.
- A new frame's command byte may arrive in the same cycle a strobe is high; it is accepted.
- Reset asserted mid-frame: the frame is dropped. All outputs clear immediately (asynchronously), and no strobe is issued after reset release.

## Structure
- Shared package sys_ctrl_pkg holds:
  - command codes CMD_RF_WR, CMD_RF_RD, CMD_ALU_OP, CMD_ALU_NOP;
  - the state encoding;
  - fixed operand addresses OPA_ADDR=0 and OPB_ADDR=1.
  - The transmit-side controller imports the same package.
- One sub-module, frame_timer: a clear/enable down-counter with parameter TIMEOUT and an expiry output.
- The FSM and output registers are in the top module.

## Test plan
- Bytes AA, 05, 3C back-to-back → one cycle later WrEn=1 for one cycle, Address=5, WrData=0x3C; RdEn, ALU_EN and CLK_EN stay 0.
- Bytes BB, 1A → RdEn=1 for one cycle with Address=0xA (upper nibble dropped); no WrEn.
- Bytes CC, 07, 03, 02 with gaps of 10 cycles:
  - WrEn pulse with Address=0, WrData=7;
  - WrEn pulse with Address=1, WrData=3;
  - CLK_EN=1 from entry into ALU_FUN_W through the ALU_EN pulse, with ALU_FUN=2; CLK_EN=0 afterwards.
- Bytes 55 then DD, 08 → 0x55 ignored; ALU_EN pulse with ALU_FUN=8 and CLK_EN high.
- Bytes AA, 03, then silence for TIMEOUT cycles, then 3C → no WrEn; block is in IDLE; 0x3C is treated as an unknown command and ignored.
- RST low one cycle after AA, 03 → all outputs 0 immediately. A following byte 3C produces no strobe, and a complete AA frame after that works normally.
